// File: rtl/ahb_pkg.sv
// Shared types and constants for the two-requester AHB master arbiter.
package ahb_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StIssue  = 2'd1,
    StWaitRd = 2'd2
  } state_e;

  typedef enum logic {
    OwnM0 = 1'b0,
    OwnM1 = 1'b1
  } owner_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
  } req_t;

endpackage

// File: rtl/ahb_req_slot.sv
// One-deep request holding register; captures a request only while empty.
module ahb_req_slot
  import ahb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  input  logic [1:0]  size,
  input  logic        clr,
  output logic        busy,
  output req_t        req
);

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      req  <= '0;
    end else if (!busy && (rd_en || wr_en)) begin
      // A simultaneous read and write request is taken as a write.
      busy <= 1'b1;
      req  <= '{wr: wr_en, addr: addr, data: wr_data, size: size};
    end else if (clr) begin
      busy <= 1'b0;
    end
  end

endmodule

// File: rtl/ahb_master_arbiter.sv
// Shares one AHB master port between requesters m0 and m1, one transfer at a time.
// Optional read-response timeout is enabled with `define AHB_TIMEOUT_EN.
module ahb_master_arbiter
  import ahb_pkg::*;
#(
  parameter int unsigned FIXED_PRIO  = 0,
  parameter int unsigned TIMEOUT_CYC = 256,
  parameter logic [31:0] ERR_DATA    = ERR_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_rd_en,
  input  logic        m0_wr_en,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wr_data,
  input  logic [1:0]  m0_size,
  output logic [31:0] m0_rd_data,
  output logic        m0_rd_vld,
  output logic        m0_busy,
  output logic        m0_err,
  input  logic        m1_rd_en,
  input  logic        m1_wr_en,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wr_data,
  input  logic [1:0]  m1_size,
  output logic [31:0] m1_rd_data,
  output logic        m1_rd_vld,
  output logic        m1_busy,
  output logic        m1_err,
  output logic        ahb_rd_en,
  output logic        ahb_wr_en,
  output logic [31:0] ahb_addr,
  output logic [31:0] ahb_wr_data,
  output logic [1:0]  ahb_size,
  input  logic [31:0] ahb_rd_data,
  input  logic        ahb_rd_vld,
  input  logic        ahb_busy
);

  state_e      state_q;
  owner_e      owner_q, last_grant_q, gnt_owner;
  req_t        s0_req, s1_req, gnt_req;
  logic        s0_clr, s1_clr, rd_done, xfer_done;
  logic [31:0] rd_word;

  ahb_req_slot u_slot0 (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (m0_rd_en),
    .wr_en   (m0_wr_en),
    .addr    (m0_addr),
    .wr_data (m0_wr_data),
    .size    (m0_size),
    .clr     (s0_clr),
    .busy    (m0_busy),
    .req     (s0_req)
  );

  ahb_req_slot u_slot1 (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (m1_rd_en),
    .wr_en   (m1_wr_en),
    .addr    (m1_addr),
    .wr_data (m1_wr_data),
    .size    (m1_size),
    .clr     (s1_clr),
    .busy    (m1_busy),
    .req     (s1_req)
  );

`ifdef AHB_TIMEOUT_EN
  localparam int unsigned CntW = ($clog2(TIMEOUT_CYC) > 8) ? $clog2(TIMEOUT_CYC) : 8;
  logic [CntW-1:0] cnt_q;
  logic            rd_err;
`endif

  always_comb begin
    // m1 wins only if alone, or on a tie under round-robin when m0 was served last.
    gnt_owner = (m1_busy && (!m0_busy || (FIXED_PRIO == 0 && last_grant_q == OwnM0))) ?
                OwnM1 : OwnM0;
    gnt_req   = (gnt_owner == OwnM1) ? s1_req : s0_req;

    rd_done = (state_q == StWaitRd) && ahb_rd_vld;
    rd_word = ahb_rd_data;
`ifdef AHB_TIMEOUT_EN
    rd_err  = 1'b0;
    if ((state_q == StWaitRd) && !ahb_rd_vld && (cnt_q == CntW'(TIMEOUT_CYC - 1))) begin
      rd_done = 1'b1;
      rd_word = ERR_DATA;
      rd_err  = 1'b1;
    end
`endif

    xfer_done = ((state_q == StIssue) && ahb_wr_en && !ahb_busy) || rd_done;
    s0_clr    = xfer_done && (owner_q == OwnM0);
    s1_clr    = xfer_done && (owner_q == OwnM1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      owner_q      <= OwnM0;
      last_grant_q <= OwnM1;
      ahb_rd_en    <= 1'b0;
      ahb_wr_en    <= 1'b0;
      ahb_addr     <= '0;
      ahb_wr_data  <= '0;
      ahb_size     <= '0;
      m0_rd_data   <= '0;
      m0_rd_vld    <= 1'b0;
      m1_rd_data   <= '0;
      m1_rd_vld    <= 1'b0;
`ifdef AHB_TIMEOUT_EN
      m0_err       <= 1'b0;
      m1_err       <= 1'b0;
      cnt_q        <= '0;
`endif
    end else begin
      m0_rd_vld <= 1'b0;
      m1_rd_vld <= 1'b0;
`ifdef AHB_TIMEOUT_EN
      m0_err    <= 1'b0;
      m1_err    <= 1'b0;
`endif
      case (state_q)
        StIdle: begin
          if (m0_busy || m1_busy) begin
            owner_q      <= gnt_owner;
            last_grant_q <= gnt_owner;
            ahb_addr     <= gnt_req.addr;
            ahb_wr_data  <= gnt_req.data;
            ahb_size     <= gnt_req.size;
            ahb_wr_en    <= gnt_req.wr;
            ahb_rd_en    <= !gnt_req.wr;
            state_q      <= StIssue;
          end
        end
        StIssue: begin
          if (!ahb_busy) begin
            ahb_rd_en <= 1'b0;
            ahb_wr_en <= 1'b0;
            state_q   <= ahb_wr_en ? StIdle : StWaitRd;
`ifdef AHB_TIMEOUT_EN
            cnt_q     <= '0;
`endif
          end
        end
        StWaitRd: begin
`ifdef AHB_TIMEOUT_EN
          cnt_q <= cnt_q + CntW'(1);
`endif
          if (rd_done) begin
            if (owner_q == OwnM0) begin
              m0_rd_data <= rd_word;
              m0_rd_vld  <= 1'b1;
`ifdef AHB_TIMEOUT_EN
              m0_err     <= rd_err;
`endif
            end else begin
              m1_rd_data <= rd_word;
              m1_rd_vld  <= 1'b1;
`ifdef AHB_TIMEOUT_EN
              m1_err     <= rd_err;
`endif
            end
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifndef AHB_TIMEOUT_EN
  assign m0_err = 1'b0;
  assign m1_err = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed self-checking bench: round-robin DUT plus a fixed-priority twin on shared stimulus.
module tb_ahb_master_arbiter;
  import ahb_pkg::*;

  localparam int unsigned TimeoutCyc = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_rd_en, m0_wr_en, m1_rd_en, m1_wr_en;
  logic [31:0] m0_addr, m0_wr_data, m1_addr, m1_wr_data;
  logic [1:0]  m0_size, m1_size;
  logic [31:0] ahb_rd_data;
  logic        ahb_rd_vld, ahb_busy;

  logic [31:0] m0_rd_data, m1_rd_data, ahb_addr, ahb_wr_data;
  logic        m0_rd_vld, m1_rd_vld, m0_busy, m1_busy, m0_err, m1_err, ahb_rd_en, ahb_wr_en;
  logic [1:0]  ahb_size;

  logic [31:0] fp_m0_rd_data, fp_m1_rd_data, fp_ahb_addr, fp_ahb_wr_data;
  logic        fp_m0_rd_vld, fp_m1_rd_vld, fp_m0_busy, fp_m1_busy, fp_m0_err, fp_m1_err;
  logic        fp_ahb_rd_en, fp_ahb_wr_en;
  logic [1:0]  fp_ahb_size;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ahb_master_arbiter #(.FIXED_PRIO(0), .TIMEOUT_CYC(TimeoutCyc)) u_dut (
    .clk(clk), .rst(rst),
    .m0_rd_en(m0_rd_en), .m0_wr_en(m0_wr_en), .m0_addr(m0_addr), .m0_wr_data(m0_wr_data),
    .m0_size(m0_size), .m0_rd_data(m0_rd_data), .m0_rd_vld(m0_rd_vld), .m0_busy(m0_busy),
    .m0_err(m0_err),
    .m1_rd_en(m1_rd_en), .m1_wr_en(m1_wr_en), .m1_addr(m1_addr), .m1_wr_data(m1_wr_data),
    .m1_size(m1_size), .m1_rd_data(m1_rd_data), .m1_rd_vld(m1_rd_vld), .m1_busy(m1_busy),
    .m1_err(m1_err),
    .ahb_rd_en(ahb_rd_en), .ahb_wr_en(ahb_wr_en), .ahb_addr(ahb_addr),
    .ahb_wr_data(ahb_wr_data), .ahb_size(ahb_size), .ahb_rd_data(ahb_rd_data),
    .ahb_rd_vld(ahb_rd_vld), .ahb_busy(ahb_busy)
  );

  ahb_master_arbiter #(.FIXED_PRIO(1), .TIMEOUT_CYC(TimeoutCyc)) u_dut_fp (
    .clk(clk), .rst(rst),
    .m0_rd_en(m0_rd_en), .m0_wr_en(m0_wr_en), .m0_addr(m0_addr), .m0_wr_data(m0_wr_data),
    .m0_size(m0_size), .m0_rd_data(fp_m0_rd_data), .m0_rd_vld(fp_m0_rd_vld),
    .m0_busy(fp_m0_busy), .m0_err(fp_m0_err),
    .m1_rd_en(m1_rd_en), .m1_wr_en(m1_wr_en), .m1_addr(m1_addr), .m1_wr_data(m1_wr_data),
    .m1_size(m1_size), .m1_rd_data(fp_m1_rd_data), .m1_rd_vld(fp_m1_rd_vld),
    .m1_busy(fp_m1_busy), .m1_err(fp_m1_err),
    .ahb_rd_en(fp_ahb_rd_en), .ahb_wr_en(fp_ahb_wr_en), .ahb_addr(fp_ahb_addr),
    .ahb_wr_data(fp_ahb_wr_data), .ahb_size(fp_ahb_size), .ahb_rd_data(ahb_rd_data),
    .ahb_rd_vld(ahb_rd_vld), .ahb_busy(ahb_busy)
  );

  // Requests are only legal while the requester's slot is empty.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!((m0_rd_en || m0_wr_en) && m0_busy)) else $error("m0 request while busy");
      assert (!((m1_rd_en || m1_wr_en) && m1_busy)) else $error("m1 request while busy");
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic r0, input logic w0, input logic r1, input logic w1);
    m0_rd_en = r0; m0_wr_en = w0; m1_rd_en = r1; m1_wr_en = w1;
    tick();
    m0_rd_en = 1'b0; m0_wr_en = 1'b0; m1_rd_en = 1'b0; m1_wr_en = 1'b0;
  endtask

  task automatic wait_bus(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ahb_rd_en || ahb_wr_en) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Waits for a read issue (accepted immediately), returns data next cycle.
  task automatic serve_read(input logic [31:0] data, output logic [31:0] addr,
                            output logic [31:0] fp_addr);
    logic ok;
    wait_bus(ok);
    check("rd_issue_seen", 32'(ok && ahb_rd_en && fp_ahb_rd_en), 32'd1);
    addr    = ahb_addr;
    fp_addr = fp_ahb_addr;
    tick();
    ahb_rd_vld  = 1'b1;
    ahb_rd_data = data;
    tick();
    ahb_rd_vld  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a, fa;
    logic        ok, seen;

    rst = 1'b1;
    m0_rd_en = 0; m0_wr_en = 0; m1_rd_en = 0; m1_wr_en = 0;
    m0_addr = '0; m1_addr = '0; m0_wr_data = '0; m1_wr_data = '0;
    m0_size = SIZE_WORD; m1_size = SIZE_WORD;
    ahb_rd_data = '0; ahb_rd_vld = 1'b0; ahb_busy = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_ahb_en", 32'({ahb_rd_en, ahb_wr_en}), 32'd0);
    check("rst_busy", 32'({m0_busy, m1_busy}), 32'd0);
    check("rst_vld_err", 32'({m0_rd_vld, m1_rd_vld, m0_err, m1_err}), 32'd0);
    check("rst_addr", ahb_addr, 32'd0);

    // Test 1: m0 write, minimum latency.
    m0_addr = 32'h0000_1000; m0_wr_data = 32'h1234_5678; m0_size = SIZE_WORD;
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    check("t1_c1_busy", 32'(m0_busy), 32'd1);
    check("t1_c1_wr_en", 32'(ahb_wr_en), 32'd0);
    tick();
    check("t1_c2_wr_en", 32'(ahb_wr_en), 32'd1);
    check("t1_c2_rd_en", 32'(ahb_rd_en), 32'd0);
    check("t1_c2_addr", ahb_addr, 32'h0000_1000);
    check("t1_c2_wdata", ahb_wr_data, 32'h1234_5678);
    check("t1_c2_size", 32'(ahb_size), 32'(SIZE_WORD));
    check("t1_c2_busy", 32'(m0_busy), 32'd1);
    tick();
    check("t1_c3_wr_en", 32'(ahb_wr_en), 32'd0);
    check("t1_c3_busy", 32'(m0_busy), 32'd0);

    // Test 2: m1 read stalled by ahb_busy for 4 cycles.
    m1_addr = 32'h0000_0020; m1_size = SIZE_HALF;
    ahb_busy = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    seen = 1'b1;
    for (int i = 0; i < 4; i++) begin
      seen &= ahb_rd_en;
      tick();
    end
    ahb_busy = 1'b0;
    check("t2_rd_en_held4", 32'(seen && ahb_rd_en), 32'd1);
    check("t2_addr", ahb_addr, 32'h0000_0020);
    check("t2_size", 32'(ahb_size), 32'(SIZE_HALF));
    tick();
    check("t2_rd_en_drop", 32'(ahb_rd_en), 32'd0);
    tick(); tick();
    ahb_rd_vld = 1'b1; ahb_rd_data = 32'hCAFE_0001;
    tick();
    ahb_rd_vld = 1'b0;
    check("t2_m1_vld", 32'(m1_rd_vld), 32'd1);
    check("t2_m1_data", m1_rd_data, 32'hCAFE_0001);
    check("t2_m1_busy", 32'(m1_busy), 32'd0);
    check("t2_m0_quiet", 32'({m0_rd_vld, m0_busy, m0_err}), 32'd0);
    // Stray bus response while idle must be ignored.
    ahb_rd_vld = 1'b1; ahb_rd_data = 32'h0BAD_0BAD;
    tick();
    ahb_rd_vld = 1'b0;
    check("t2_m1_vld_pulse", 32'(m1_rd_vld), 32'd0);
    tick();
    check("t2_stray_ignored", 32'({m0_rd_vld, m1_rd_vld}), 32'd0);

    // Test 3: arbitration. Round 1 tie: both instances serve m0 first.
    m0_addr = 32'h0000_0100; m1_addr = 32'h0000_0200;
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    serve_read(32'hA000_0001, a, fa);
    check("t3_r1_g0_rr", a, 32'h0000_0100);
    check("t3_r1_g0_fp", fa, 32'h0000_0100);
    check("t3_r1_g0_m0vld", 32'({m0_rd_vld, fp_m0_rd_vld}), 32'b11);
    check("t3_r1_g0_data", m0_rd_data, 32'hA000_0001);
    serve_read(32'hA000_0002, a, fa);
    check("t3_r1_g1_rr", a, 32'h0000_0200);
    check("t3_r1_g1_fp", fa, 32'h0000_0200);
    check("t3_r1_g1_m1vld", 32'({m1_rd_vld, fp_m1_rd_vld}), 32'b11);
    check("t3_r1_g1_data", m1_rd_data, 32'hA000_0002);
    // Solo m0 read leaves last_grant = m0.
    m0_addr = 32'h0000_0110;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    serve_read(32'hA000_0003, a, fa);
    check("t3_solo_rr", a, 32'h0000_0110);
    // Round 2 tie: round-robin picks m1, fixed priority picks m0.
    m0_addr = 32'h0000_0100;
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    serve_read(32'hA000_0004, a, fa);
    check("t3_r2_g0_rr", a, 32'h0000_0200);
    check("t3_r2_g0_fp", fa, 32'h0000_0100);
    check("t3_r2_g0_vld", 32'({m1_rd_vld, m0_rd_vld, fp_m0_rd_vld, fp_m1_rd_vld}), 32'b1010);
    serve_read(32'hA000_0005, a, fa);
    check("t3_r2_g1_rr", a, 32'h0000_0100);
    check("t3_r2_g1_fp", fa, 32'h0000_0200);
    check("t3_r2_g1_data", m0_rd_data, 32'hA000_0005);
    check("t3_r2_g1_fpdata", fp_m1_rd_data, 32'hA000_0005);

    // Test 4: reset while waiting for read data, late response afterwards.
    m0_addr = 32'h0000_0300;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    wait_bus(ok);
    check("t4_issue_seen", 32'(ok && ahb_rd_en), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick(); tick();
    ahb_rd_vld = 1'b1; ahb_rd_data = 32'h5555_AAAA;
    tick();
    ahb_rd_vld = 1'b0;
    check("t4_no_vld", 32'({m0_rd_vld, m1_rd_vld}), 32'd0);
    check("t4_busy", 32'({m0_busy, m1_busy}), 32'd0);
    check("t4_ahb_en", 32'({ahb_rd_en, ahb_wr_en}), 32'd0);
    tick();
    check("t4_no_vld_late", 32'({m0_rd_vld, m1_rd_vld}), 32'd0);
    check("t4_rd_data", m0_rd_data, 32'd0);

    // Test 6: rd_en and wr_en together are a single write.
    m0_addr = 32'h0000_0040; m0_wr_data = 32'h0000_0066;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    wait_bus(ok);
    check("t6_wr_en", 32'(ok && ahb_wr_en), 32'd1);
    check("t6_addr", ahb_addr, 32'h0000_0040);
    seen = ahb_rd_en;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen |= ahb_rd_en | ahb_wr_en;
    end
    check("t6_no_rd_or_second", 32'(seen), 32'd0);
    check("t6_busy_clear", 32'(m0_busy), 32'd0);
    check("t6_err_low", 32'({m0_err, m1_err}), 32'd0);

`ifdef AHB_TIMEOUT_EN
    // Test 5: read never answered times out after TimeoutCyc cycles.
    m0_addr = 32'h0000_0500;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    wait_bus(ok);
    check("t5_issue_seen", 32'(ok && ahb_rd_en), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      seen |= m0_rd_vld | m0_err;
    end
    check("t5_not_early", 32'(seen), 32'd0);
    tick();
    check("t5_vld", 32'(m0_rd_vld), 32'd1);
    check("t5_err", 32'(m0_err), 32'd1);
    check("t5_data", m0_rd_data, 32'hDEAD_BEEF);
    check("t5_busy", 32'(m0_busy), 32'd0);
    tick();
    check("t5_err_pulse", 32'({m0_err, m0_rd_vld}), 32'd0);
    m0_addr = 32'h0000_0504;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    serve_read(32'h7777_0001, a, fa);
    check("t5_next_addr", a, 32'h0000_0504);
    check("t5_next_vld", 32'({m0_rd_vld, m0_err}), 32'b10);
    check("t5_next_data", m0_rd_data, 32'h7777_0001);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
